arc4_encrypt: RTL and testbench
===============================

# arc4_encrypt

Encryption-side ARC4 engine: produces length-prefixed ciphertext from a length-prefixed plaintext buffer and a 24-bit key. It sits on the other end of the key-search/decrypt datapath and generates the ciphertext memories that the cracking engine consumes. It uses the same `en`/`rdy` start handshake and the same single-port, 1-cycle-latency memory interface as the other ARC4 blocks.

## Interface
Parameters:
- `KEY_W`, 24: key width; key bytes are taken big-endian, `key[23:16]` is byte 0.
- `MAX_LEN`, 255: maximum message length; the length byte is clamped to this value.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: start request; sampled only while `rdy`=1.
- `rdy` out 1: engine idle and able to accept `en`.
- `key` in 24: key; latched on the accepting edge.
- `s_addr` out 8, `s_wrdata` out 8, `s_wren` out 1, `s_rddata` in 8: state-array memory (256×8).
- `pt_addr` out 8, `pt_rddata` in 8: plaintext memory; byte 0 is length L.
- `ct_addr` out 8, `ct_wrdata` out 8, `ct_wren` out 1: ciphertext memory; byte 0 is length L.
- `err` out 1: plaintext rejected (only with `ARC4_ENC_PT_CHECK_EN`).

## Operation
- All memories: read data is valid in the cycle after the address is presented. A write occurs on the edge where `wren`=1.
- States: IDLE → INIT → KSA → LEN → PRGA → DONE → IDLE.
- IDLE: `rdy`=1. When `en`=1, latch `key`, clear `i`, `j`, and `err`, then go to INIT.
- INIT: 256 cycles. Cycle n writes `s[n]=n`.
- KSA: 4 cycles per `i`=0..255.
  - c1: `s_addr=i`.
  - c2: capture `si`; `j=(j+si+keybyte[i mod 3]) mod 256`; `s_addr=j`.
  - c3: capture `sj`; write `s[i]=sj`.
  - c4: write `s[j]=si`.
  - After `i`=255, clear `i` and `j`.
- LEN: 2 cycles.
  - c1: `pt_addr=0`.
  - c2: `L=min(pt_rddata,MAX_LEN)`; write `ct[0]=L`.
- PRGA: 6 cycles per `k`=1..L. The state uses the 8-bit `i` counter.
  - c1: `i=i+1`; `s_addr=i`; `pt_addr=k`.
  - c2: capture `si` and `ptk`; `j=j+si`; `s_addr=j`.
  - c3: capture `sj`; write `s[i]=sj`.
  - c4: write `s[j]=si`.
  - c5: `s_addr=(si+sj) mod 256`.
  - c6: write `ct[k]=s_rddata^ptk`.
  - If L=0, skip straight to DONE.
- DONE: 1 cycle, then IDLE.
- Arithmetic: all 8-bit, wrapping mod 256. `k` wraps never, because L≤255.
- `en` while `rdy`=0 is ignored; it is not queued.
- `key` changes after acceptance have no effect.

## Timing
- Reset values:
  - Outputs: `rdy`=1, `err`=0, every `*_wren`=0, every address/data output 0.
  - State = IDLE; `i`=`j`=0.
- `rst` mid-operation returns to IDLE on the next edge. No further memory writes occur. Partially written ct contents are left as-is.
- `rdy` falls on the edge after acceptance.
- `rdy` rises exactly 1283+6·L cycles after the accepting edge (1283 when L=0).
- Back-to-back: `en` held high in the first `rdy`=1 cycle starts a new run immediately.
- `*_wren` is high only in the write cycles listed above; at most one write per memory per cycle.

## Configuration
- `ARC4_ENC_PT_CHECK_EN` defined:
  - In PRGA c2, a plaintext byte outside 0x20–0x7E sets `err`=1.
  - That byte's ct write is suppressed and the engine goes to DONE.
  - `err` holds until the next acceptance or `rst`.
  - Timing then equals 1283+6·(k−1)+2 cycles for a bad byte at `k`.
- Not defined: `err` is tied 0 and all bytes are encrypted.

## Test plan
- Known vector:
  - Stimulus: key=0x4B6579 ("Key"); pt = 9,"Plaintext".
  - Required: ct = 09 BB F3 16 E8 D9 40 AF 0A D3; `rdy` returns after 1337 cycles.
- L=0:
  - Stimulus: pt[0]=0.
  - Required: single write `ct[0]=00`; `rdy` after 1283 cycles; no other ct writes.
- Reset mid-KSA:
  - Stimulus: assert `rst` 500 cycles after start.
  - Required: next cycle `rdy`=1, all `wren`=0. A following run with key 0x4B6579 reproduces the known vector.
- Ignored `en`:
  - Stimulus: pulse `en` and change `key` while `rdy`=0.
  - Required: output is unchanged; cycle count is unchanged.
- Round trip:
  - Stimulus: key=0x000018, 20-byte printable pt. Feed ct to the decrypt/crack path.
  - Required: recovered pt is identical and the cracker reports key 0x000018.
- With `ARC4_ENC_PT_CHECK_EN`:
  - Stimulus: pt = 3,"A",0x0A,"B".
  - Required: `ct[0]=03`, `ct[1]` written, `ct[2..3]` untouched; `err`=1; `rdy` after 1283+6+2=1291 cycles.

Source files
------------

// File: rtl/arc4_encrypt.sv
// ARC4 encryption engine: length-prefixed plaintext in, length-prefixed ciphertext out.
// Optional plaintext range check enabled by defining ARC4_ENC_PT_CHECK_EN.
module arc4_encrypt #(
    parameter int KEY_W   = 24,
    parameter int MAX_LEN = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             rdy,
    input  logic [KEY_W-1:0] key,
    output logic [7:0]       s_addr,
    output logic [7:0]       s_wrdata,
    output logic             s_wren,
    input  logic [7:0]       s_rddata,
    output logic [7:0]       pt_addr,
    input  logic [7:0]       pt_rddata,
    output logic [7:0]       ct_addr,
    output logic [7:0]       ct_wrdata,
    output logic             ct_wren,
    output logic             err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_INIT = 3'd1;
    localparam logic [2:0] ST_KSA  = 3'd2;
    localparam logic [2:0] ST_LEN  = 3'd3;
    localparam logic [2:0] ST_PRGA = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam int unsigned KB      = KEY_W / 8;
    localparam logic [7:0]  LEN_CAP = 8'(MAX_LEN);

    logic [2:0]       r_state;
    logic [2:0]       r_ph;
    logic [7:0]       r_i;
    logic [7:0]       r_j;
    logic [7:0]       r_si;
    logic [7:0]       r_sj;
    logic [7:0]       r_ptk;
    logic [7:0]       r_k;
    logic [7:0]       r_len;
    logic [7:0]       r_kidx;
    logic [KEY_W-1:0] r_key;

    logic [7:0] w_kbyte;
    logic [7:0] w_j_ksa;
    logic [7:0] w_j_prga;
    logic [7:0] w_i_inc;
    logic [7:0] w_len;

    // Key bytes are big-endian: byte 0 is the most significant.
    always_comb begin
        w_kbyte = '0;
        for (int unsigned b = 0; b < KB; b++) begin
            if (r_kidx == 8'(b)) w_kbyte = r_key[KEY_W-1-8*b -: 8];
        end
    end

    assign w_j_ksa  = r_j + s_rddata + w_kbyte;
    assign w_j_prga = r_j + s_rddata;
    assign w_i_inc  = r_i + 8'd1;
    assign w_len    = (pt_rddata > LEN_CAP) ? LEN_CAP : pt_rddata;
    assign rdy      = (r_state == ST_IDLE);

`ifdef ARC4_ENC_PT_CHECK_EN
    logic r_err;
    logic w_bad;
    assign w_bad = (pt_rddata < 8'h20) || (pt_rddata > 8'h7E);
    assign err   = r_err;
`else
    assign err = 1'b0;
`endif

    // Memory controls are decoded from state/phase so read data lands in the next phase.
    always_comb begin
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        pt_addr   = '0;
        ct_addr   = '0;
        ct_wrdata = '0;
        ct_wren   = 1'b0;
        case (r_state)
            ST_INIT: begin
                s_addr   = r_i;
                s_wrdata = r_i;
                s_wren   = 1'b1;
            end
            ST_KSA: begin
                case (r_ph)
                    3'd0: s_addr = r_i;
                    3'd1: s_addr = w_j_ksa;
                    3'd2: begin s_addr = r_i; s_wrdata = s_rddata; s_wren = 1'b1; end
                    default: begin s_addr = r_j; s_wrdata = r_si; s_wren = 1'b1; end
                endcase
            end
            ST_LEN: begin
                if (r_ph != 3'd0) begin
                    ct_wrdata = w_len;
                    ct_wren   = 1'b1;
                end
            end
            ST_PRGA: begin
                case (r_ph)
                    3'd0: begin s_addr = w_i_inc; pt_addr = r_k; end
                    3'd1: s_addr = w_j_prga;
                    3'd2: begin s_addr = r_i; s_wrdata = s_rddata; s_wren = 1'b1; end
                    3'd3: begin s_addr = r_j; s_wrdata = r_si; s_wren = 1'b1; end
                    3'd4: s_addr = r_si + r_sj;
                    default: begin
                        ct_addr   = r_k;
                        ct_wrdata = s_rddata ^ r_ptk;
                        ct_wren   = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ph    <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_ptk   <= '0;
            r_k     <= '0;
            r_len   <= '0;
            r_kidx  <= '0;
            r_key   <= '0;
`ifdef ARC4_ENC_PT_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_key   <= key;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_kidx  <= '0;
                        r_ph    <= '0;
                        r_state <= ST_INIT;
`ifdef ARC4_ENC_PT_CHECK_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                ST_INIT: begin
                    r_i <= w_i_inc;
                    if (r_i == 8'hFF) r_state <= ST_KSA;
                end
                ST_KSA: begin
                    r_ph <= r_ph + 3'd1;
                    if (r_ph == 3'd1) begin
                        r_si <= s_rddata;
                        r_j  <= w_j_ksa;
                    end else if (r_ph == 3'd3) begin
                        r_ph   <= '0;
                        r_i    <= w_i_inc;
                        r_kidx <= (r_kidx == 8'(KB - 1)) ? 8'd0 : r_kidx + 8'd1;
                        if (r_i == 8'hFF) begin
                            r_j     <= '0;
                            r_state <= ST_LEN;
                        end
                    end
                end
                ST_LEN: begin
                    r_ph <= r_ph + 3'd1;
                    if (r_ph != 3'd0) begin
                        r_len   <= w_len;
                        r_k     <= 8'd1;
                        r_ph    <= '0;
                        r_state <= (w_len == 8'd0) ? ST_DONE : ST_PRGA;
                    end
                end
                ST_PRGA: begin
                    r_ph <= r_ph + 3'd1;
                    case (r_ph)
                        3'd0: r_i <= w_i_inc;
                        3'd1: begin
                            r_si  <= s_rddata;
                            r_ptk <= pt_rddata;
                            r_j   <= w_j_prga;
`ifdef ARC4_ENC_PT_CHECK_EN
                            if (w_bad) begin
                                r_err   <= 1'b1;
                                r_ph    <= '0;
                                r_state <= ST_DONE;
                            end
`endif
                        end
                        3'd2: r_sj <= s_rddata;
                        3'd5: begin
                            r_ph <= '0;
                            if (r_k == r_len) r_state <= ST_DONE;
                            else              r_k     <= r_k + 8'd1;
                        end
                        default: ;
                    endcase
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed self-checking bench for arc4_encrypt with behavioural 1-cycle-latency memories.
module tb_arc4_encrypt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [23:0] key = '0;
    logic        rdy;
    logic [7:0]  s_addr, s_wrdata, s_rddata;
    logic        s_wren;
    logic [7:0]  pt_addr, pt_rddata;
    logic [7:0]  ct_addr, ct_wrdata;
    logic        ct_wren;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    int         ct_gen [256];
    int         ct_wr_cnt = 0;
    int         run_id = 0;

    localparam logic [23:0] KV_KEY = 24'h4B6579;
    logic [7:0] exp_kv [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    arc4_encrypt #(.KEY_W(24), .MAX_LEN(255)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren), .s_rddata(s_rddata),
        .pt_addr(pt_addr), .pt_rddata(pt_rddata),
        .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        s_rddata  <= s_mem[s_addr];
        pt_rddata <= pt_mem[pt_addr];
        if (s_wren) s_mem[s_addr] <= s_wrdata;
        if (ct_wren) begin
            ct_mem[ct_addr] <= ct_wrdata;
            ct_gen[ct_addr] <= run_id;
            ct_wr_cnt       <= ct_wr_cnt + 1;
        end
    end

    task automatic load_pt(input string s);
        pt_mem[0] = 8'(s.len());
        for (int i = 0; i < s.len(); i++) pt_mem[i+1] = s[i];
    endtask

    // Starts a run and returns the number of edges from acceptance until rdy is seen high.
    task automatic run_enc(input logic [23:0] k, output int cyc);
        run_id++;
        @(negedge clk);
        en  = 1'b1;
        key = k;
        @(posedge clk);
        #1;
        en  = 1'b0;
        cyc = 0;
        while (rdy !== 1'b1 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
        tests++;
        if ({s_wren, ct_wren} !== 2'b00) begin fails++; $display("FAIL reset_wren: got %b expected 00", {s_wren, ct_wren}); end
        tests++;
        if ({s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata} !== 40'h0) begin
            fails++;
            $display("FAIL reset_outs: got %h expected 0", {s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_known_vector;
        int cyc;
        int wc0;
        load_pt("Plaintext");
        wc0 = ct_wr_cnt;
        run_enc(KV_KEY, cyc);
        tests++;
        if (cyc !== 1337) begin fails++; $display("FAIL kv_cycles: got %0d expected 1337", cyc); end
        tests++;
        if (ct_wr_cnt - wc0 !== 10) begin fails++; $display("FAIL kv_writes: got %0d expected 10", ct_wr_cnt - wc0); end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (ct_gen[i] != run_id || ct_mem[i] !== exp_kv[i]) begin
                fails++;
                $display("FAIL kv_ct[%0d]: got %h expected %h", i, ct_mem[i], exp_kv[i]);
            end
        end
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL kv_err: got %b expected 0", err); end
    endtask

    task automatic test_len_zero;
        int cyc;
        int wc0;
        pt_mem[0] = 8'd0;
        wc0 = ct_wr_cnt;
        run_enc(KV_KEY, cyc);
        tests++;
        if (cyc !== 1283) begin fails++; $display("FAIL len0_cycles: got %0d expected 1283", cyc); end
        tests++;
        if (ct_wr_cnt - wc0 !== 1) begin fails++; $display("FAIL len0_writes: got %0d expected 1", ct_wr_cnt - wc0); end
        tests++;
        if (ct_gen[0] != run_id || ct_mem[0] !== 8'h00) begin
            fails++;
            $display("FAIL len0_ct0: got %h expected 00", ct_mem[0]);
        end
    endtask

    task automatic test_reset_mid;
        int wc0;
        load_pt("Plaintext");
        run_id++;
        @(negedge clk);
        en  = 1'b1;
        key = KV_KEY;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (499) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wc0 = ct_wr_cnt;
        @(posedge clk);
        #1;
        tests++;
        if (rdy !== 1'b1) begin fails++; $display("FAIL rstmid_rdy: got %b expected 1", rdy); end
        tests++;
        if ({s_wren, ct_wren} !== 2'b00) begin fails++; $display("FAIL rstmid_wren: got %b expected 00", {s_wren, ct_wren}); end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (ct_wr_cnt != wc0 || rdy !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_idle: got writes %0d rdy %b expected writes 0 rdy 1", ct_wr_cnt - wc0, rdy);
        end
        test_known_vector();
    endtask

    task automatic test_ignored_en;
        int cyc;
        load_pt("Plaintext");
        run_id++;
        @(negedge clk);
        en  = 1'b1;
        key = KV_KEY;
        @(posedge clk);
        #1;
        en  = 1'b0;
        cyc = 0;
        while (rdy !== 1'b1 && cyc < 5000) begin
            en = (cyc == 100 || cyc == 900 || cyc == 1300);
            if (en) key = 24'hA5A5A5 ^ 24'(cyc);
            @(posedge clk);
            #1;
            cyc++;
        end
        en = 1'b0;
        tests++;
        if (cyc !== 1337) begin fails++; $display("FAIL ign_cycles: got %0d expected 1337", cyc); end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (ct_gen[i] != run_id || ct_mem[i] !== exp_kv[i]) begin
                fails++;
                $display("FAIL ign_ct[%0d]: got %h expected %h", i, ct_mem[i], exp_kv[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        load_pt("Plaintext");
        run_id++;
        @(negedge clk);
        en  = 1'b1;
        key = KV_KEY;
        @(posedge clk);
        #1;
        cyc = 0;
        while (rdy !== 1'b1 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        tests++;
        if (cyc !== 1337) begin fails++; $display("FAIL b2b_cycles1: got %0d expected 1337", cyc); end
        run_id++;
        @(posedge clk);
        #1;
        tests++;
        if (rdy !== 1'b0) begin fails++; $display("FAIL b2b_restart: got rdy %b expected 0", rdy); end
        en  = 1'b0;
        cyc = 0;
        while (rdy !== 1'b1 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        tests++;
        if (cyc !== 1337) begin fails++; $display("FAIL b2b_cycles2: got %0d expected 1337", cyc); end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (ct_gen[i] != run_id || ct_mem[i] !== exp_kv[i]) begin
                fails++;
                $display("FAIL b2b_ct[%0d]: got %h expected %h", i, ct_mem[i], exp_kv[i]);
            end
        end
    endtask

`ifndef ARC4_ENC_PT_CHECK_EN
    task automatic test_roundtrip;
        int         cyc;
        int         ndiff;
        string      msg;
        logic [7:0] ct_save [20];
        msg = "ROUNDTRIP-TEST-12345";
        load_pt(msg);
        run_enc(24'h000018, cyc);
        tests++;
        if (cyc !== 1403) begin fails++; $display("FAIL rt_cycles1: got %0d expected 1403", cyc); end
        ndiff = 0;
        for (int i = 0; i < 20; i++) begin
            ct_save[i] = ct_mem[i+1];
            if (ct_mem[i+1] !== msg[i]) ndiff++;
        end
        tests++;
        if (ndiff < 10) begin fails++; $display("FAIL rt_scrambled: got %0d differing bytes expected at least 10", ndiff); end
        pt_mem[0] = 8'd20;
        for (int i = 0; i < 20; i++) pt_mem[i+1] = ct_save[i];
        run_enc(24'h000018, cyc);
        tests++;
        if (cyc !== 1403) begin fails++; $display("FAIL rt_cycles2: got %0d expected 1403", cyc); end
        tests++;
        if (ct_gen[0] != run_id || ct_mem[0] !== 8'd20) begin fails++; $display("FAIL rt_len: got %h expected 14", ct_mem[0]); end
        for (int i = 0; i < 20; i++) begin
            tests++;
            if (ct_gen[i+1] != run_id || ct_mem[i+1] !== msg[i]) begin
                fails++;
                $display("FAIL rt_pt[%0d]: got %h expected %h", i + 1, ct_mem[i+1], msg[i]);
            end
        end
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL rt_err: got %b expected 0", err); end
    endtask
`else
    task automatic test_pt_check;
        int cyc;
        int wc0;
        pt_mem[0] = 8'd3;
        pt_mem[1] = 8'h41;
        pt_mem[2] = 8'h0A;
        pt_mem[3] = 8'h42;
        wc0 = ct_wr_cnt;
        run_enc(KV_KEY, cyc);
        tests++;
        if (cyc !== 1291) begin fails++; $display("FAIL chk_cycles: got %0d expected 1291", cyc); end
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL chk_err: got %b expected 1", err); end
        tests++;
        if (ct_wr_cnt - wc0 !== 2) begin fails++; $display("FAIL chk_writes: got %0d expected 2", ct_wr_cnt - wc0); end
        tests++;
        if (ct_gen[0] != run_id || ct_mem[0] !== 8'h03) begin fails++; $display("FAIL chk_ct0: got %h expected 03", ct_mem[0]); end
        tests++;
        if (ct_gen[1] != run_id || ct_mem[1] !== 8'hAA) begin fails++; $display("FAIL chk_ct1: got %h expected aa", ct_mem[1]); end
        tests++;
        if (ct_gen[2] == run_id || ct_gen[3] == run_id) begin
            fails++;
            $display("FAIL chk_untouched: got gen %0d/%0d expected not %0d", ct_gen[2], ct_gen[3], run_id);
        end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (err !== 1'b1) begin fails++; $display("FAIL chk_err_hold: got %b expected 1", err); end
        test_known_vector();
    endtask
`endif

    initial begin
        test_reset();
        test_known_vector();
        test_len_zero();
        test_reset_mid();
        test_ignored_en();
        test_back_to_back();
`ifndef ARC4_ENC_PT_CHECK_EN
        test_roundtrip();
`else
        test_pt_check();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
